// File: rtl/dc_frame_reader.sv
// Frame timer for the MAROC pulse counters: strobes latch_out each frame, snapshots
// the latched counts and streams them as one AXI-Stream packet (header + packed counts).
module dc_frame_reader #(
    parameter int NCH = 64,
    parameter int CW  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [31:0]       frame_len,
    output logic              latch_out,
    input  logic [NCH*CW-1:0] counts_in,
    output logic [31:0]       m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic [31:0]       frame_num,
    output logic [15:0]       overrun_cnt
);
    localparam int NW        = NCH / 2;
    localparam int KW        = $clog2(NW + 1);
    localparam int MIN_FRAME = NCH / 2 + 4;

    typedef enum logic [1:0] {IDLE, WAIT_CAP, HDR, DATA} state_t;

    state_t            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [31:0]       tcnt_q, flen_q, flen_cur;
    logic              latch_q, cap_pend_q, first_q;
    logic [31:0]       frame_num_q;
    logic [15:0]       ovr_q, hdr_num_q;
    logic              hdr_first_q;
    logic [NCH*CW-1:0] shad_q;
    logic [CW-1:0]     lo_c, hi_c;
    logic              can_cap, accept, last_word, wrap;

    // Frame length is only picked up at the start of a frame.
    assign flen_cur = (tcnt_q != 32'd0) ? flen_q :
                      (frame_len < 32'(MIN_FRAME)) ? 32'(MIN_FRAME) : frame_len;
    assign wrap     = (tcnt_q == flen_cur - 32'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt_q  <= '0;
            flen_q  <= '0;
            latch_q <= 1'b0;
        end else if (!enable) begin
            tcnt_q  <= '0;
            latch_q <= 1'b0;
        end else begin
            latch_q <= wrap;
            tcnt_q  <= wrap ? 32'd0 : tcnt_q + 32'd1;
            if (tcnt_q == 32'd0) flen_q <= flen_cur;
        end
    end

    // Counters present fresh values one cycle after the latch strobe.
    assign can_cap   = cap_pend_q && (state_q == IDLE || state_q == WAIT_CAP);
    assign accept    = m_tvalid && m_tready;
    assign last_word = (k_q == KW'(NW - 1));

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            IDLE:     if (latch_q) state_d = WAIT_CAP;
            WAIT_CAP: state_d = WAIT_CAP;
            HDR:      if (accept) begin
                          state_d = DATA;
                          k_d     = '0;
                      end
            DATA:     if (accept) begin
                          if (last_word) state_d = IDLE;
                          else           k_d     = k_q + KW'(1);
                      end
            default:  state_d = IDLE;
        endcase
        if (can_cap) state_d = HDR;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            k_q         <= '0;
            cap_pend_q  <= 1'b0;
            first_q     <= 1'b1;
            frame_num_q <= '0;
            ovr_q       <= '0;
            hdr_num_q   <= '0;
            hdr_first_q <= 1'b0;
            shad_q      <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            cap_pend_q <= latch_q;
            if (latch_q) frame_num_q <= frame_num_q + 32'd1;
            if (can_cap) begin
                shad_q      <= counts_in;
                hdr_num_q   <= frame_num_q[15:0] - 16'd1;
                hdr_first_q <= first_q;
            end else if (cap_pend_q && ovr_q != 16'hFFFF) begin
                ovr_q <= ovr_q + 16'd1;
            end
            if (!enable)      first_q <= 1'b1;
            else if (can_cap) first_q <= 1'b0;
        end
    end

    assign lo_c = shad_q[32'(k_q) * (2 * CW) +: CW];
    assign hi_c = shad_q[32'(k_q) * (2 * CW) + CW +: CW];

    assign m_tvalid    = (state_q == HDR) || (state_q == DATA);
    assign m_tlast     = (state_q == DATA) && last_word;
    assign m_tdata     = (state_q == HDR) ? {8'hDC, 7'b0, hdr_first_q, hdr_num_q}
                                          : {16'(hi_c), 16'(lo_c)};
    assign latch_out   = latch_q;
    assign frame_num   = frame_num_q;
    assign overrun_cnt = ovr_q;
endmodule

// File: tb/tb_dc_frame_reader.sv
// Scoreboard bench for dc_frame_reader with NCH=4: directed frames, backpressure,
// enable drop and mid-packet reset.
module tb_dc_frame_reader;
    localparam int NCH = 4;
    localparam int CW  = 16;

    logic              clk = 1'b0;
    logic              reset, enable, m_tready;
    logic [31:0]       frame_len;
    logic [NCH*CW-1:0] counts_in;
    logic              latch_out, m_tvalid, m_tlast;
    logic [31:0]       m_tdata, frame_num;
    logic [15:0]       overrun_cnt;

    dc_frame_reader #(.NCH(NCH), .CW(CW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .frame_len(frame_len),
        .latch_out(latch_out), .counts_in(counts_in), .m_tdata(m_tdata),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .frame_num(frame_num), .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [32:0] exp_q[$];
    int          exp_period = 100;
    int          lat_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_pkt(input logic first, input logic [15:0] num);
        exp_q.push_back({1'b0, 8'hDC, 7'b0, first, num});
        exp_q.push_back({1'b0, 32'h0002_0001});
        exp_q.push_back({1'b1, 32'h0004_0003});
    endtask

    task automatic wait_latch();
        int n = 0;
        @(negedge clk);
        while (!latch_out && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!latch_out) chk("latch_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            tick();
            n++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard monitor plus AXI-Stream stability checks.
    logic        prev_stall = 1'b0;
    logic [32:0] stall_word;
    always @(negedge clk) begin
        logic [32:0] e;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("valid_held", 64'(m_tvalid), 64'd1);
                chk("stall_stable", 64'({m_tlast, m_tdata}), 64'(stall_word));
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 64'({m_tlast, m_tdata}), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("word", 64'({m_tlast, m_tdata}), 64'(e));
                end
            end
            prev_stall = m_tvalid && !m_tready;
            stall_word = {m_tlast, m_tdata};
        end
    end

    // Latch period, one-cycle width, and latch-to-valid latency.
    int   cyc = 0;
    int   last_lat = -1;
    logic prev_lat = 1'b0;
    logic prev_vld = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (reset || !enable) begin
            last_lat = -1;
        end else if (latch_out) begin
            lat_cnt++;
            if (prev_lat) chk("latch_width", 64'd2, 64'd1);
            if (last_lat >= 0) chk("latch_period", 64'(cyc - last_lat), 64'(exp_period));
            last_lat = cyc;
        end
        if (!reset && m_tvalid && !prev_vld && last_lat >= 0)
            chk("valid_latency", 64'(cyc - last_lat), 64'd2);
        prev_lat = latch_out;
        prev_vld = m_tvalid;
    end

    initial begin
        int lc;
        reset     = 1'b1;
        enable    = 1'b0;
        m_tready  = 1'b1;
        frame_len = 32'd100;
        counts_in = {16'd4, 16'd3, 16'd2, 16'd1};
        tick(3);
        @(negedge clk);
        chk("rst_latch", 64'(latch_out), 64'd0);
        chk("rst_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_tlast", 64'(m_tlast), 64'd0);
        chk("rst_tdata", 64'(m_tdata), 64'd0);
        chk("rst_frame_num", 64'(frame_num), 64'd0);
        chk("rst_overrun", 64'(overrun_cnt), 64'd0);
        tick();
        reset = 1'b0;

        // Two frames at frame_len=100.
        push_pkt(1'b1, 16'd0);
        push_pkt(1'b0, 16'd1);
        exp_period = 100;
        enable = 1'b1;
        wait_drain("drain_f100");
        chk("frame_num_2", 64'(frame_num), 64'd2);
        chk("overrun_0", 64'(overrun_cnt), 64'd0);

        // Short frame clamps to MIN_FRAME=6; enable dropped mid-packet after 4th latch.
        enable = 1'b0;
        tick();
        frame_len  = 32'd3;
        exp_period = 6;
        push_pkt(1'b1, 16'd2);
        push_pkt(1'b0, 16'd3);
        push_pkt(1'b0, 16'd4);
        push_pkt(1'b0, 16'd5);
        enable = 1'b1;
        repeat (4) wait_latch();
        tick(3);
        enable = 1'b0;
        lc = lat_cnt;
        wait_drain("drain_f3");
        tick(50);
        chk("no_latch_when_off", 64'(lat_cnt), 64'(lc));
        chk("frame_num_6", 64'(frame_num), 64'd6);
        chk("overrun_still_0", 64'(overrun_cnt), 64'd0);

        // Re-enable: first bit set again; reset on 2nd data word.
        frame_len  = 32'd100;
        exp_period = 100;
        exp_q.push_back({1'b0, 32'hDC01_0006});
        exp_q.push_back({1'b0, 32'h0002_0001});
        enable = 1'b1;
        wait_latch();
        tick(4);
        reset = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_mid_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_mid_tlast", 64'(m_tlast), 64'd0);
        chk("rst_mid_frame_num", 64'(frame_num), 64'd0);
        chk("rst_mid_queue", 64'(exp_q.size()), 64'd0);
        tick();
        reset = 1'b0;

        // Backpressure for 250 cycles: two frames dropped, original packet intact.
        push_pkt(1'b1, 16'd0);
        wait_latch();
        tick();
        m_tready = 1'b0;
        tick(250);
        @(negedge clk);
        chk("bp_overrun", 64'(overrun_cnt), 64'd2);
        chk("bp_frame_num", 64'(frame_num), 64'd3);
        chk("bp_queue_full", 64'(exp_q.size()), 64'd3);
        tick();
        m_tready = 1'b1;
        wait_drain("drain_bp");
        push_pkt(1'b0, 16'd3);
        wait_drain("drain_after_bp");
        chk("final_overrun", 64'(overrun_cnt), 64'd2);
        chk("final_frame_num", 64'(frame_num), 64'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
